// File: rtl/rv_wb_pkg.sv
// Shared constants and the queued writeback entry type for the register-file write side.
package rv_wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; DEPTH must be a power of two so pointers wrap naturally.
module wb_fifo
  import rv_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  wb_entry_t       push_entry,
  input  logic            pop,
  output wb_entry_t       head,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Queues ALU/load results, drives the register-file write port and tracks pending destinations.
// Optional WB_BYPASS_EN adds same-cycle forwarding of the write port to the hazard queries.
module reg_writeback_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [4:0]                   alu_rd,
  input  logic [XLEN-1:0]              alu_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [4:0]                   mem_rd,
  input  logic [XLEN-1:0]              mem_data,
  input  logic                         pend_set,
  input  logic [4:0]                   pend_rd,
  input  logic [4:0]                   rs1_q,
  input  logic [4:0]                   rs2_q,
  output logic                         rs1_busy,
  output logic                         rs2_busy,
`ifdef WB_BYPASS_EN
  output logic                         rs1_fwd_hit,
  output logic                         rs2_fwd_hit,
  output logic [XLEN-1:0]              rs1_fwd_data,
  output logic [XLEN-1:0]              rs2_fwd_data,
`endif
  output logic                         RegWrite,
  output logic [4:0]                   Rd,
  output logic [XLEN-1:0]              Write_data,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  import rv_wb_pkg::*;

  logic          full, empty, pop, push;
  logic          mem_acc, alu_acc;
  wb_entry_t     push_entry, head;
  logic [NUM_REGS-1:0] pending_q, pending_d;

  // Load wins arbitration; full is sampled before the same-cycle pop.
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign mem_acc   = mem_valid && mem_ready;
  assign alu_acc   = alu_valid && alu_ready;
  assign push      = (mem_acc && (mem_rd != '0)) || (alu_acc && (alu_rd != '0));
  assign pop       = !empty;

  always_comb begin
    push_entry = '0;
    if (mem_acc) begin
      push_entry.rd   = mem_rd;
      push_entry.data = mem_data;
    end else begin
      push_entry.rd   = alu_rd;
      push_entry.data = alu_data;
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite   <= 1'b0;
      Rd         <= '0;
      Write_data <= '0;
    end else if (pop) begin
      RegWrite   <= 1'b1;
      Rd         <= head.rd;
      Write_data <= head.data;
    end else begin
      RegWrite   <= 1'b0;
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the register pending.
  always_comb begin
    pending_d = pending_q;
    if (RegWrite) pending_d[Rd] = 1'b0;
    if (pend_set && (pend_rd != '0)) pending_d[pend_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

`ifdef WB_BYPASS_EN
  assign rs1_fwd_hit  = RegWrite && (Rd == rs1_q) && (rs1_q != '0);
  assign rs2_fwd_hit  = RegWrite && (Rd == rs2_q) && (rs2_q != '0);
  assign rs1_fwd_data = rs1_fwd_hit ? Write_data : '0;
  assign rs2_fwd_data = rs2_fwd_hit ? Write_data : '0;
  assign rs1_busy     = pending_q[rs1_q] && !rs1_fwd_hit;
  assign rs2_busy     = pending_q[rs2_q] && !rs2_fwd_hit;
`else
  assign rs1_busy     = pending_q[rs1_q];
  assign rs2_busy     = pending_q[rs2_q];
`endif

endmodule
